// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; req/ack data-memory port, branch resolve, MEM/WB register.
// Optional ack timeout with sticky mem_err_o: define MEM_ACK_TIMEOUT_EN.
module mem_stage #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int REG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PCM_i,
  input  logic [DATA_WIDTH-1:0] imm8M_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  input  logic [DATA_WIDTH-1:0] alu_outM_i,
  input  logic [REG_WIDTH-1:0]  WriteRegM_i,
  input  logic                  RegWriteM_i,
  input  logic                  BranchM_i,
  input  logic                  MemReadM_i,
  input  logic                  MemWriteM_i,
  input  logic                  MemToRegM_i,
  input  logic                  MovM_i,
  input  logic                  flush_MEM_WB_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_ack_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  stall_mem_o,
  output logic [DATA_WIDTH-1:0] WBResultM_o,
  output logic                  branch_taken_o,
  output logic [ADDR_WIDTH-1:0] branch_target_o,
  output logic [DATA_WIDTH-1:0] ReadDataW_o,
  output logic [DATA_WIDTH-1:0] alu_outW_o,
  output logic [DATA_WIDTH-1:0] imm8W_o,
  output logic [REG_WIDTH-1:0]  WriteRegW_o,
  output logic                  RegWriteW_o,
  output logic                  MemToRegW_o,
  output logic                  MovW_o,
  output logic                  mem_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic                  mem_op;
  logic                  timeout;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign mem_op = MemReadM_i | MemWriteM_i;

  // Hold upstream while a launch is pending or an access is in flight
  assign stall_mem_o = (state == REQ) |
                       ((state == IDLE) & mem_op);

  assign WBResultM_o = MovM_i ? imm8M_i : alu_outM_i;

  // Only resolve once per instruction, from IDLE
  assign branch_taken_o = BranchM_i &
                          (alu_outM_i == '0) &
                          (state == IDLE);

  assign branch_target_o = PCM_i + imm8M_i[ADDR_WIDTH-1:0];

`ifdef MEM_ACK_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          err_q;

  assign timeout   = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign mem_err_o = err_q;

  // Count REQ cycles; cleared while idle so each access starts at 0
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == REQ) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Sticky error when an access gives up waiting for ack
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state == REQ) & ~dmem_ack_i & timeout) begin
      err_q <= 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign mem_err_o = 1'b0;
`endif

  // Access FSM with registered memory-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      rdata_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_op) begin
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= MemWriteM_i;
            dmem_addr_o  <= alu_outM_i[ADDR_WIDTH-1:0];
            dmem_wdata_o <= WriteDataM_i;
            state        <= REQ;
          end
        end
        REQ: begin
          if (dmem_ack_i) begin
            rdata_q    <= dmem_we_o ? '0 : dmem_rdata_i;
            dmem_req_o <= 1'b0;
            dmem_we_o  <= 1'b0;
            state      <= DONE;
          end else if (timeout) begin
            rdata_q    <= '0;
            dmem_req_o <= 1'b0;
            dmem_we_o  <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // MEM/WB register: bubble on flush or stall, else take EX/MEM
  always_ff @(posedge clk) begin
    if (rst | flush_MEM_WB_i | stall_mem_o) begin
      ReadDataW_o <= '0;
      alu_outW_o  <= '0;
      imm8W_o     <= '0;
      WriteRegW_o <= '0;
      RegWriteW_o <= 1'b0;
      MemToRegW_o <= 1'b0;
      MovW_o      <= 1'b0;
    end else begin
      ReadDataW_o <= (state == DONE) ? rdata_q : '0;
      alu_outW_o  <= alu_outM_i;
      imm8W_o     <= imm8M_i;
      WriteRegW_o <= WriteRegM_i;
      RegWriteW_o <= RegWriteM_i;
      MemToRegW_o <= MemToRegM_i;
      MovW_o      <= MovM_i;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage.
// Timeout checks enabled with MEM_ACK_TIMEOUT_EN.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  PCM_i;
  logic [15:0] imm8M_i, WriteDataM_i, alu_outM_i;
  logic [3:0]  WriteRegM_i;
  logic        RegWriteM_i, BranchM_i, MemReadM_i;
  logic        MemWriteM_i, MemToRegM_i, MovM_i;
  logic        flush_MEM_WB_i;
  logic        dmem_req_o, dmem_we_o;
  logic [7:0]  dmem_addr_o;
  logic [15:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [15:0] dmem_rdata_i;
  logic        stall_mem_o;
  logic [15:0] WBResultM_o;
  logic        branch_taken_o;
  logic [7:0]  branch_target_o;
  logic [15:0] ReadDataW_o, alu_outW_o, imm8W_o;
  logic [3:0]  WriteRegW_o;
  logic        RegWriteW_o, MemToRegW_o, MovW_o;
  logic        mem_err_o;

  int total = 0;
  int bad   = 0;

  int          stalls;
  int          m2r;
  logic [7:0]  addr_seen;
  logic        we_seen;
  logic [15:0] wdata_seen;

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .PCM_i          (PCM_i),
    .imm8M_i        (imm8M_i),
    .WriteDataM_i   (WriteDataM_i),
    .alu_outM_i     (alu_outM_i),
    .WriteRegM_i    (WriteRegM_i),
    .RegWriteM_i    (RegWriteM_i),
    .BranchM_i      (BranchM_i),
    .MemReadM_i     (MemReadM_i),
    .MemWriteM_i    (MemWriteM_i),
    .MemToRegM_i    (MemToRegM_i),
    .MovM_i         (MovM_i),
    .flush_MEM_WB_i (flush_MEM_WB_i),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_ack_i     (dmem_ack_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .stall_mem_o    (stall_mem_o),
    .WBResultM_o    (WBResultM_o),
    .branch_taken_o (branch_taken_o),
    .branch_target_o(branch_target_o),
    .ReadDataW_o    (ReadDataW_o),
    .alu_outW_o     (alu_outW_o),
    .imm8W_o        (imm8W_o),
    .WriteRegW_o    (WriteRegW_o),
    .RegWriteW_o    (RegWriteW_o),
    .MemToRegW_o    (MemToRegW_o),
    .MovW_o         (MovW_o),
    .mem_err_o      (mem_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nop();
    PCM_i        = '0;
    imm8M_i      = '0;
    WriteDataM_i = '0;
    alu_outM_i   = '0;
    WriteRegM_i  = '0;
    RegWriteM_i  = 0;
    BranchM_i    = 0;
    MemReadM_i   = 0;
    MemWriteM_i  = 0;
    MemToRegM_i  = 0;
    MovM_i       = 0;
  endtask

  // Run a launched access until stall drops; ack in REQ cycle ack_at
  // (0 = never). Returns stalled cycle count and first-REQ port values.
  task automatic run_mem(input int ack_at,
                         input logic [15:0] rdata,
                         output int st,
                         output logic [7:0] a,
                         output logic we,
                         output logic [15:0] wd);
    int rc;
    st = 0;
    rc = 0;
    a  = '0;
    we = 0;
    wd = '0;
    for (int c = 0; c < 40 && stall_mem_o; c++) begin
      st++;
      dmem_ack_i   = 0;
      dmem_rdata_i = 16'hDEAD;
      if (dmem_req_o) begin
        rc++;
        if (rc == 1) begin
          a  = dmem_addr_o;
          we = dmem_we_o;
          wd = dmem_wdata_o;
        end
        if (ack_at != 0 && rc == ack_at) begin
          dmem_ack_i   = 1;
          dmem_rdata_i = rdata;
        end
      end
      tick();
    end
    dmem_ack_i   = 0;
    dmem_rdata_i = '0;
  endtask

  initial begin
    rst            = 1;
    flush_MEM_WB_i = 0;
    dmem_ack_i     = 0;
    dmem_rdata_i   = '0;
    nop();
    tick();
    tick();
    chk("rst_req",   32'(dmem_req_o), 32'h0);
    chk("rst_we",    32'(dmem_we_o), 32'h0);
    chk("rst_addr",  32'(dmem_addr_o), 32'h0);
    chk("rst_wdata", 32'(dmem_wdata_o), 32'h0);
    chk("rst_err",   32'(mem_err_o), 32'h0);
    chk("rst_rw",    32'(RegWriteW_o), 32'h0);
    chk("rst_stall", 32'(stall_mem_o), 32'h0);
    rst = 0;

    // ALU op passes straight through in one cycle
    alu_outM_i  = 16'h1234;
    RegWriteM_i = 1;
    WriteRegM_i = 4'd3;
    #1;
    chk("add_stall", 32'(stall_mem_o), 32'h0);
    chk("fwd_alu",   32'(WBResultM_o), 32'h1234);
    MovM_i  = 1;
    imm8M_i = 16'h0055;
    #1;
    chk("fwd_mov", 32'(WBResultM_o), 32'h0055);
    MovM_i  = 0;
    imm8M_i = '0;
    tick();
    chk("add_alu", 32'(alu_outW_o), 32'h1234);
    chk("add_rw",  32'(RegWriteW_o), 32'h1);
    chk("add_wr",  32'(WriteRegW_o), 32'h3);
    chk("add_rd",  32'(ReadDataW_o), 32'h0);
    chk("add_st2", 32'(stall_mem_o), 32'h0);

    // Ack while idle must not start anything
    nop();
    dmem_ack_i = 1;
    tick();
    dmem_ack_i = 0;
    chk("ack_idle_req", 32'(dmem_req_o), 32'h0);
    chk("ack_idle_st",  32'(stall_mem_o), 32'h0);

    // Load, ack in third REQ cycle
    alu_outM_i  = 16'h0040;
    MemReadM_i  = 1;
    MemToRegM_i = 1;
    RegWriteM_i = 1;
    WriteRegM_i = 4'd5;
    #1;
    chk("ld_st0", 32'(stall_mem_o), 32'h1);
    run_mem(3, 16'hBEEF, stalls, addr_seen, we_seen, wdata_seen);
    chk("ld_stalls", 32'(stalls), 32'd4);
    chk("ld_addr",   32'(addr_seen), 32'h40);
    chk("ld_we",     32'(we_seen), 32'h0);
    chk("ld_req_dn", 32'(dmem_req_o), 32'h0);
    m2r = int'(MemToRegW_o);
    tick();
    chk("ld_rdata", 32'(ReadDataW_o), 32'hBEEF);
    chk("ld_wr",    32'(WriteRegW_o), 32'h5);
    m2r += int'(MemToRegW_o);
    nop();
    tick();
    m2r += int'(MemToRegW_o);
    chk("ld_m2r_once", 32'(m2r), 32'd1);
    chk("ld_nolaunch", 32'(dmem_req_o), 32'h0);

    // Store, ack in first REQ cycle; read data forced to 0
    alu_outM_i   = 16'h0010;
    WriteDataM_i = 16'h00A5;
    MemWriteM_i  = 1;
    #1;
    run_mem(1, 16'h7777, stalls, addr_seen, we_seen, wdata_seen);
    chk("st_stalls", 32'(stalls), 32'd2);
    chk("st_we",     32'(we_seen), 32'h1);
    chk("st_wdata",  32'(wdata_seen), 32'h00A5);
    chk("st_addr",   32'(addr_seen), 32'h10);
    tick();
    chk("st_rw", 32'(RegWriteW_o), 32'h0);
    chk("st_rd", 32'(ReadDataW_o), 32'h0);
    nop();
    tick();

    // Branch resolve with wrapping target
    BranchM_i  = 1;
    PCM_i      = 8'hFE;
    imm8M_i    = 16'h0004;
    alu_outM_i = 16'h0000;
    #1;
    chk("br_taken", 32'(branch_taken_o), 32'h1);
    chk("br_tgt",   32'(branch_target_o), 32'h02);
    alu_outM_i = 16'h0001;
    #1;
    chk("br_not", 32'(branch_taken_o), 32'h0);
    nop();

    // Flush beats a normal MEM/WB load
    alu_outM_i     = 16'h4321;
    RegWriteM_i    = 1;
    WriteRegM_i    = 4'd7;
    flush_MEM_WB_i = 1;
    tick();
    flush_MEM_WB_i = 0;
    chk("fl_rw",  32'(RegWriteW_o), 32'h0);
    chk("fl_alu", 32'(alu_outW_o), 32'h0);
    nop();

    // Reset in the middle of a store access
    alu_outM_i   = 16'h0033;
    WriteDataM_i = 16'h5A5A;
    MemWriteM_i  = 1;
    tick();
    chk("rq_req", 32'(dmem_req_o), 32'h1);
    chk("rq_we",  32'(dmem_we_o), 32'h1);
    BranchM_i  = 1;
    alu_outM_i = 16'h0000;
    #1;
    chk("rq_nobr", 32'(branch_taken_o), 32'h0);
    rst = 1;
    tick();
    rst = 0;
    nop();
    #1;
    chk("rr_req",   32'(dmem_req_o), 32'h0);
    chk("rr_we",    32'(dmem_we_o), 32'h0);
    chk("rr_addr",  32'(dmem_addr_o), 32'h0);
    chk("rr_wdata", 32'(dmem_wdata_o), 32'h0);
    chk("rr_rd",    32'(ReadDataW_o), 32'h0);
    chk("rr_alu",   32'(alu_outW_o), 32'h0);
    chk("rr_m2r",   32'(MemToRegW_o), 32'h0);
    chk("rr_stall", 32'(stall_mem_o), 32'h0);
    BranchM_i = 1;
    #1;
    chk("rr_idle_br", 32'(branch_taken_o), 32'h1);
    nop();
    tick();

`ifdef MEM_ACK_TIMEOUT_EN
    // Load that never gets ack gives up after 15 REQ cycles
    alu_outM_i  = 16'h0080;
    MemReadM_i  = 1;
    MemToRegM_i = 1;
    RegWriteM_i = 1;
    #1;
    run_mem(0, 16'h0, stalls, addr_seen, we_seen, wdata_seen);
    chk("to_stalls", 32'(stalls), 32'd16);
    chk("to_req",    32'(dmem_req_o), 32'h0);
    chk("to_err",    32'(mem_err_o), 32'h1);
    tick();
    chk("to_rd",  32'(ReadDataW_o), 32'h0);
    chk("to_m2r", 32'(MemToRegW_o), 32'h1);
    nop();
    tick();
    tick();
    chk("to_sticky", 32'(mem_err_o), 32'h1);
    rst = 1;
    tick();
    rst = 0;
    chk("to_clr", 32'(mem_err_o), 32'h0);
`else
    chk("err_tied", 32'(mem_err_o), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
